// File: rtl/ethernet_fmc_rst_pkg.sv
// Shared types and constants for the FMC clock-domain reset sequencer.
package ethernet_fmc_rst_pkg;

  // Sequencer state encoding, also exported on state_o for debug.
  typedef enum logic [2:0] {
    ST_MMCM_RST  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } rst_state_e;

  localparam int LOSS_CNT_W = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

  // Largest of four cycle counts; sizes the single shared phase timer.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ethernet_fmc_sync_bit.sv
// Single-bit synchroniser with parameterised depth; all stages reset to 0.
module ethernet_fmc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (!reset_n) chain <= '0;
    else          chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ethernet_fmc_rst_seq.sv
// MMCM reset sequencer: pulses mmcm_reset, waits for a stable lock (retrying
// on timeout), then releases NUM_CH active-low resets in order, bit 0 first.
// Optional lock-loss counter is built when RST_SEQ_LOSS_CNT_EN is defined;
// otherwise lock_loss_cnt is tied to 0.
// Interface note: there is no valid/ready handshake on this block.
// sw_rst_req is a single-cycle pulse, acted on in the cycle it is high
// (except in MMCM_RST, where an attempt is already in progress and it is
// dropped); nothing acknowledges it.
module ethernet_fmc_rst_seq
  import ethernet_fmc_rst_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int MMCM_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int STABLE_CYCLES   = 1024,
  parameter int STAGE_DELAY     = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mmcm_locked,
  input  logic                  sw_rst_req,
  output logic                  mmcm_reset,
  output logic [NUM_CH-1:0]     ch_rst_n,
  output logic                  all_ready,
  output logic [2:0]            state_o,
  output logic                  timeout_err,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam logic [2:0] S_MMCM_RST  = ST_MMCM_RST;
  localparam logic [2:0] S_WAIT_LOCK = ST_WAIT_LOCK;
  localparam logic [2:0] S_STABLE    = ST_STABLE;
  localparam logic [2:0] S_RELEASE   = ST_RELEASE;
  localparam logic [2:0] S_RUN       = ST_RUN;

  // One timer serves every phase, so it is sized for the longest one.
  localparam int TMR_MAX = max4(LOCK_TIMEOUT, STABLE_CYCLES, MMCM_RST_CYCLES,
                                NUM_CH * STAGE_DELAY);
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(MMCM_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);

  logic              lk;
  logic [2:0]        state, nxt_state;
  logic [TMR_W-1:0]  tmr, nxt_tmr;
  logic [NUM_CH-1:0] ch_q, nxt_ch;
  logic              ready_q, nxt_ready;
  logic              terr_q, nxt_terr;
  logic              lk_abort, sw_abort;

  ethernet_fmc_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (mmcm_locked),
    .q       (lk)
  );

  assign lk_abort = !lk && ((state == S_RELEASE) || (state == S_RUN));
  assign sw_abort = sw_rst_req && (state != S_MMCM_RST);

  // Next-state, timer and output decisions; any abort restarts from MMCM_RST.
  always_comb begin
    nxt_state = state;
    nxt_tmr   = tmr + 1'b1;
    nxt_ch    = ch_q;
    nxt_ready = ready_q;
    nxt_terr  = terr_q;
    if (lk_abort || sw_abort) begin
      nxt_state = S_MMCM_RST;
      nxt_tmr   = '0;
      nxt_ch    = '0;
      nxt_ready = 1'b0;
    end else begin
      case (state)
        S_MMCM_RST: begin
          if (tmr == RST_LAST) begin
            nxt_state = S_WAIT_LOCK;
            nxt_tmr   = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (lk) begin
            nxt_state = S_STABLE;
            nxt_tmr   = '0;
          end else if (tmr == TO_LAST) begin
            nxt_state = S_MMCM_RST;
            nxt_tmr   = '0;
            nxt_terr  = 1'b1;
          end
        end
        S_STABLE: begin
          if (!lk) begin
            nxt_state = S_WAIT_LOCK;
            nxt_tmr   = '0;
          end else if (tmr == STB_LAST) begin
            nxt_state = S_RELEASE;
            nxt_tmr   = '0;
          end
        end
        S_RELEASE: begin
          if (&ch_q) begin
            nxt_state = S_RUN;
            nxt_tmr   = tmr;
            nxt_ready = 1'b1;
          end else begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (tmr == TMR_W'((i + 1) * STAGE_DELAY - 1)) nxt_ch[i] = 1'b1;
            end
          end
        end
        S_RUN: begin
          nxt_tmr = tmr;
        end
        default: begin
          nxt_state = S_MMCM_RST;
          nxt_tmr   = '0;
          nxt_ch    = '0;
          nxt_ready = 1'b0;
        end
      endcase
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_MMCM_RST;
      tmr     <= '0;
      ch_q    <= '0;
      ready_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state   <= nxt_state;
      tmr     <= nxt_tmr;
      ch_q    <= nxt_ch;
      ready_q <= nxt_ready;
      terr_q  <= nxt_terr;
    end
  end

`ifdef RST_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q;

  // Count lock losses in RELEASE/RUN, saturating at the top value.
  always_ff @(posedge clk) begin
    if (!reset_n)                                 loss_q <= '0;
    else if (lk_abort && (loss_q != LOSS_CNT_MAX)) loss_q <= loss_q + 1'b1;
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = '0;
`endif

  assign mmcm_reset  = (state == S_MMCM_RST);
  assign ch_rst_n    = ch_q;
  assign all_ready   = ready_q;
  assign state_o     = state;
  assign timeout_err = terr_q;

endmodule
